// File: rtl/motion_detector_array.sv
// Pipelined per-pixel motion detector. Each beat carries LANES pixels; every
// lane is tested against the background model and the previous frame using a
// variance-scaled threshold. Produces a per-lane motion mask and a per-frame
// count of moving pixels, with valid/ready flow control.
module motion_detector_array #(
  parameter int PIX_W     = 8,
  parameter int LANES     = 4,
  parameter int VAR_SHIFT = 2,
  parameter int CNT_W     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [PIX_W-1:0]       threshold,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic                   in_eof,
  input  logic [LANES*PIX_W-1:0] curr_pixel,
  input  logic [LANES*PIX_W-1:0] prev_pixel,
  input  logic [LANES*PIX_W-1:0] background,
  input  logic [LANES*PIX_W-1:0] variance,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       motion_mask,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   count_valid
);

  // Effective threshold carries one extra bit so threshold + scaled variance never wraps.
  localparam int THR_W = PIX_W + 1;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [CNT_W:0] popcount(input logic [LANES-1:0] m);
    logic [CNT_W:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + {{CNT_W{1'b0}}, m[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + b;
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic             adv;
  logic             out_hs;

  logic [PIX_W-1:0] bg_diff_c [LANES];
  logic [PIX_W-1:0] fr_diff_c [LANES];
  logic [THR_W-1:0] eff_thr_c [LANES];

  logic             vld_p1;
  logic [1:0]       mode_p1;
  logic             sof_p1, eof_p1;
  logic [PIX_W-1:0] bg_diff_p1 [LANES];
  logic [PIX_W-1:0] fr_diff_p1 [LANES];
  logic [THR_W-1:0] eff_thr_p1 [LANES];

  logic [LANES-1:0] bg_hit_c, fr_hit_c, mask_c;

  logic             vld_p2;
  logic [LANES-1:0] mask_p2;
  logic             sof_p2, eof_p2;

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_next;

  // Whole pipeline moves together; it stalls only when the output beat is held.
  assign adv      = !vld_p2 || out_ready;
  assign in_ready = adv;
  assign out_hs   = vld_p2 && out_ready;

  // Per-lane absolute differences and variance-scaled threshold.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bg_diff_c[i] = abs_diff(curr_pixel[i*PIX_W +: PIX_W], background[i*PIX_W +: PIX_W]);
      fr_diff_c[i] = abs_diff(curr_pixel[i*PIX_W +: PIX_W], prev_pixel[i*PIX_W +: PIX_W]);
      eff_thr_c[i] = {1'b0, threshold} + {1'b0, (variance[i*PIX_W +: PIX_W] >> VAR_SHIFT)};
    end
  end

  // ---- stage 1: differences, threshold, mode and framing flags ----
  // Stage 1 valid: clears when the pipeline advances with no beat entering.
  always_ff @(posedge clk) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= in_valid;
  end

  // Stage 1 data: captured only with an accepted beat, so mode/threshold follow the beat.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      mode_p1 <= mode;
      sof_p1  <= in_sof;
      eof_p1  <= in_eof;
      for (int i = 0; i < LANES; i++) begin
        bg_diff_p1[i] <= bg_diff_c[i];
        fr_diff_p1[i] <= fr_diff_c[i];
        eff_thr_p1[i] <= eff_thr_c[i];
      end
    end
  end

  // Strict compares and mode selection of the lane result.
  always_comb begin
    bg_hit_c = '0;
    fr_hit_c = '0;
    for (int i = 0; i < LANES; i++) begin
      bg_hit_c[i] = {1'b0, bg_diff_p1[i]} > eff_thr_p1[i];
      fr_hit_c[i] = {1'b0, fr_diff_p1[i]} > eff_thr_p1[i];
    end
    case (mode_p1)
      2'd0:    mask_c = bg_hit_c;
      2'd1:    mask_c = fr_hit_c;
      2'd2:    mask_c = bg_hit_c & fr_hit_c;
      default: mask_c = bg_hit_c | fr_hit_c;
    endcase
  end

  // ---- stage 2: motion mask and framing flags at the output ----
  // Stage 2 registers: hold while stalled, load only when stage 1 has a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      mask_p2 <= '0;
      sof_p2  <= 1'b0;
      eof_p2  <= 1'b0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mask_p2 <= mask_c;
        sof_p2  <= sof_p1;
        eof_p2  <= eof_p1;
      end
    end
  end

  // An sof beat restarts the count from zero, discarding any partial frame.
  assign acc_next = sat_add(sof_p2 ? '0 : acc, popcount(mask_p2));

  // Frame accumulator; reports on the eof handshake and pulses one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      frame_count <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= out_hs && eof_p2;
      if (out_hs) begin
        acc <= acc_next;
        if (eof_p2) frame_count <= acc_next;
      end
    end
  end

  assign out_valid   = vld_p2;
  assign motion_mask = mask_p2;
  assign out_sof     = sof_p2;
  assign out_eof     = eof_p2;

endmodule
